// File: rtl/disparity_pkg.sv
// Shared types and constants for the disparity post-processing stream.
//   fill_state_e : gap-fill FSM state (SEED, TRACK, GAP)
//   disparity_t  : disparity word at the default DISP_W
//   DEF_*        : default raster geometry
//   cnt_w()      : counter width that never collapses to zero bits
package disparity_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_DISP_W     = 8;

  typedef logic [DEF_DISP_W-1:0] disparity_t;

  typedef enum logic [1:0] {
    SEED  = 2'd0,   // no reliable pixel yet on this row
    TRACK = 2'd1,   // last pixel was reliable
    GAP   = 2'd2    // inside a run of unreliable pixels
  } fill_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster position tracker driven by a pixel strobe.
//   clk, rst_n : clock, async active-low reset
//   valid      : one pixel this cycle
//   col, row   : position of the pixel currently on the strobe
//   eol, eof   : combinational flags, high with the last pixel of a row / frame
// Counters only advance on valid cycles, so gaps in the stream are harmless.
module raster_pos_counter
  import disparity_pkg::*;
#(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  localparam int COL_W      = cnt_w(IMG_WIDTH),
  localparam int ROW_W      = cnt_w(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             eol,
  output logic             eof
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  assign eol = valid && (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disparity_gap_fill.sv
// Fills unreliable disparity pixels with the last reliable value on the same
// scanline, for at most MAX_GAP consecutive pixels. A pixel is reliable when it
// is not homogeneous and its disparity is non-zero. All outputs are registered
// (1-cycle latency); invalid cycles hold o_disparity and clear the flags.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_pure_disparity     : aligned centre-pixel disparity
//   i_homogeneity        : 1 = homogeneous (unreliable) pixel
//   i_pure_valid         : pixel strobe
//   o_disparity, o_valid : filled disparity and its strobe
//   o_filled             : 1 = o_disparity is substituted
//   o_eol, o_eof         : last pixel of row / frame
// Optional macro DISP_GAP_FILL_STATS_EN adds o_fill_count: number of filled
// pixels in the previous frame, latched on the frame's last pixel.
module disparity_gap_fill
  import disparity_pkg::*;
#(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter  int DISP_W     = DEF_DISP_W,
  parameter  int MAX_GAP    = 32,
  localparam int FCW        = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DISP_W-1:0] i_pure_disparity,
  input  logic              i_homogeneity,
  input  logic              i_pure_valid,
  output logic [DISP_W-1:0] o_disparity,
  output logic              o_valid,
  output logic              o_filled,
  output logic              o_eol,
  output logic              o_eof
`ifdef DISP_GAP_FILL_STATS_EN
  ,
  output logic [FCW-1:0]    o_fill_count
`endif
);

  localparam int              GW      = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0]   GAP_MAX = GW'(MAX_GAP);

  if (IMG_WIDTH < 2 || MAX_GAP < 1) begin : g_bad_param
    $error("disparity_gap_fill: IMG_WIDTH must be >= 2 and MAX_GAP >= 1");
  end

  logic        eol, eof;
  logic [cnt_w(IMG_WIDTH)-1:0]  col;
  logic [cnt_w(IMG_HEIGHT)-1:0] row;

  raster_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .valid (i_pure_valid),
    .col   (col),
    .row   (row),
    .eol   (eol),
    .eof   (eof)
  );

  // Position is exposed for other consumers; only the flags matter here.
  logic unused_pos;
  assign unused_pos = ^{col, row};

  fill_state_e       state_q, state_d;
  logic [DISP_W-1:0] last_good_q, last_good_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DISP_W-1:0] disp_d;
  logic              filled_d;
  logic              good;

  assign good = !i_homogeneity && (i_pure_disparity != '0);

  always_comb begin
    state_d     = state_q;
    last_good_d = last_good_q;
    gap_d       = gap_q;
    disp_d      = i_pure_disparity;
    filled_d    = 1'b0;
    unique case (state_q)
      SEED: begin
        if (good) begin
          last_good_d = i_pure_disparity;
          state_d     = TRACK;
        end else begin
          disp_d   = '0;
          filled_d = 1'b1;
        end
      end
      TRACK: begin
        if (good) begin
          last_good_d = i_pure_disparity;
        end else begin
          disp_d   = last_good_q;
          filled_d = 1'b1;
          gap_d    = GW'(1);
          state_d  = GAP;
        end
      end
      GAP: begin
        if (good) begin
          last_good_d = i_pure_disparity;
          gap_d       = '0;
          state_d     = TRACK;
        end else if (gap_q < GAP_MAX) begin
          disp_d   = last_good_q;
          filled_d = 1'b1;
          gap_d    = gap_q + 1'b1;
        end else begin
          // Gap too long to trust the old value: emit 0, keep counter pinned.
          disp_d   = '0;
          filled_d = 1'b1;
          gap_d    = GAP_MAX;
        end
      end
      default: state_d = SEED;
    endcase
    // The row's last pixel is processed above; nothing carries into the next row.
    if (eol) begin
      state_d     = SEED;
      last_good_d = '0;
      gap_d       = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= SEED;
      last_good_q <= '0;
      gap_q       <= '0;
      o_disparity <= '0;
      o_valid     <= 1'b0;
      o_filled    <= 1'b0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      o_valid  <= i_pure_valid;
      o_filled <= 1'b0;
      o_eol    <= 1'b0;
      o_eof    <= 1'b0;
      if (i_pure_valid) begin
        state_q     <= state_d;
        last_good_q <= last_good_d;
        gap_q       <= gap_d;
        o_disparity <= disp_d;
        o_filled    <= filled_d;
        o_eol       <= eol;
        o_eof       <= eof;
      end
    end
  end

`ifdef DISP_GAP_FILL_STATS_EN
  logic [FCW-1:0] fill_cnt_q;

  // Total is published together with o_eof and held for the whole next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt_q   <= '0;
      o_fill_count <= '0;
    end else if (i_pure_valid) begin
      if (eof) begin
        o_fill_count <= fill_cnt_q + FCW'(filled_d);
        fill_cnt_q   <= '0;
      end else if (filled_d) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_disparity_gap_fill.sv
// Bench for disparity_gap_fill at IMG_WIDTH=8, IMG_HEIGHT=2, MAX_GAP=2.
// Reference model: each output is derived from the history of pixels already
// seen on the current row (search back for the last reliable pixel, fill only
// if it is within MAX_GAP pixels), with row/column taken from the pixel index.
module tb_disparity_gap_fill;

  localparam int W    = 8;
  localparam int H    = 2;
  localparam int MAXG = 2;
  localparam int FCW  = $clog2(W * H + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       hin = 1'b0;
  logic       vin = 1'b0;
  logic [7:0] o_disparity;
  logic       o_valid, o_filled, o_eol, o_eof;
`ifdef DISP_GAP_FILL_STATS_EN
  logic [FCW-1:0] o_fill_count;
`endif

  always #5 clk = ~clk;

  disparity_gap_fill #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DISP_W     (8),
    .MAX_GAP    (MAXG)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_pure_disparity (din),
    .i_homogeneity    (hin),
    .i_pure_valid     (vin),
    .o_disparity      (o_disparity),
    .o_valid          (o_valid),
    .o_filled         (o_filled),
    .o_eol            (o_eol),
    .o_eof            (o_eof)
`ifdef DISP_GAP_FILL_STATS_EN
    ,
    .o_fill_count     (o_fill_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] hd[$];
  bit         hh[$];
  logic [7:0] exp_last;
  int         fcnt;
  int         exp_fill_count;

  task automatic model_clear();
    hd.delete();
    hh.delete();
    exp_last = '0;
    fcnt = 0;
    exp_fill_count = 0;
  endtask

  task automatic model(input logic [7:0] d, input bit h,
                       output logic [7:0] ed, output bit ef, output bit eol, output bit eof);
    int n   = hd.size();
    int col = n % W;
    int row = (n / W) % H;
    int lg  = -1;
    hd.push_back(d);
    hh.push_back(h);
    if (!h && d != 0) begin
      ed = d;
      ef = 1'b0;
    end else begin
      ed = '0;
      ef = 1'b1;
      for (int j = n - 1; j >= n - col; j--) begin
        if (!hh[j] && hd[j] != 0) begin
          lg = j;
          break;
        end
      end
      if (lg >= 0 && (n - lg) <= MAXG) ed = hd[lg];
    end
    eol = (col == W - 1);
    eof = eol && (row == H - 1);
  endtask

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic px(input bit v, input logic [7:0] d, input bit h);
    logic [7:0] ed;
    bit ef, eol, eof;
    @(negedge clk);
    vin = v; din = d; hin = h;
    @(posedge clk);
    #1;
    if (v) begin
      model(d, h, ed, ef, eol, eof);
      exp_last = ed;
      if (ef) fcnt++;
      if (eof) begin
        exp_fill_count = fcnt;
        fcnt = 0;
      end
    end else begin
      ed = exp_last; ef = 1'b0; eol = 1'b0; eof = 1'b0;
    end
    chk("m_valid",  o_valid,     v);
    chk("m_disp",   o_disparity, ed);
    chk("m_filled", o_filled,    ef);
    chk("m_eol",    o_eol,       eol);
    chk("m_eof",    o_eof,       eof);
`ifdef DISP_GAP_FILL_STATS_EN
    chk("m_fill_count", o_fill_count, exp_fill_count);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [7:0] d;
    bit         h;
    logic [7:0] ed;
    bit         ef;
    bit         eol;
    bit         eof;
  } vec_t;

  vec_t tbl[16];

  logic [7:0] r2_d [8] = '{8'd0, 8'd0, 8'd9, 8'd7, 8'd7, 8'd7, 8'd4, 8'd4};
  bit         r2_h [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  logic [7:0] r2_ed[8] = '{8'd0, 8'd0, 8'd9, 8'd9, 8'd9, 8'd0, 8'd4, 8'd4};
  bit         r2_ef[8] = '{1, 1, 0, 1, 1, 1, 0, 0};

  initial begin
    int eof_seen;
    logic [7:0] rd;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{d: 8'(5 + i), h: 1'b0, ed: 8'(5 + i), ef: 1'b0, eol: (i == 7), eof: 1'b0};
      tbl[8 + i] = '{d: r2_d[i], h: r2_h[i], ed: r2_ed[i], ef: r2_ef[i], eol: (i == 7), eof: (i == 7)};
    end
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp",   o_disparity, 0);
    chk("rst_valid",  o_valid,     0);
    chk("rst_filled", o_filled,    0);
    chk("rst_eol",    o_eol,       0);
    chk("rst_eof",    o_eof,       0);
`ifdef DISP_GAP_FILL_STATS_EN
    chk("rst_fill_count", o_fill_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame from the table
    for (int i = 0; i < 16; i++) begin
      px(1'b1, tbl[i].d, tbl[i].h);
      chk("tbl_disp",   o_disparity, tbl[i].ed);
      chk("tbl_filled", o_filled,    tbl[i].ef);
      chk("tbl_eol",    o_eol,       tbl[i].eol);
      chk("tbl_eof",    o_eof,       tbl[i].eof);
    end
    px(1'b0, 8'd0, 1'b0);
`ifdef DISP_GAP_FILL_STATS_EN
    chk("stats_frame5", o_fill_count, 5);
`endif
    // Next frame count starts from zero: one filled pixel, then a clean rest
    px(1'b1, 8'd0, 1'b1);
    for (int i = 1; i < 16; i++) px(1'b1, 8'd20, 1'b0);
`ifdef DISP_GAP_FILL_STATS_EN
    chk("stats_frame1", o_fill_count, 1);
`endif

    // Same frame with the strobe toggling every other cycle
    do_reset();
    eof_seen = 0;
    for (int i = 0; i < 16; i++) begin
      px(1'b1, tbl[i].d, tbl[i].h);
      chk("tog_disp",   o_disparity, tbl[i].ed);
      chk("tog_filled", o_filled,    tbl[i].ef);
      chk("tog_eol",    o_eol,       tbl[i].eol);
      if (o_eof) eof_seen++;
      px(1'b0, 8'd99, 1'b0);
      chk("tog_hold",   o_disparity, tbl[i].ed);
      if (o_eof) eof_seen++;
    end
    chk("tog_eof_once", eof_seen, 1);

    // Row ending inside a gap; next row must start unseeded
    do_reset();
    px(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 7; i++) px(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    chk("gap_row_eol", o_eol, 1);
    px(1'b1, 8'd0, 1'b0);
    chk("seed_after_gap_disp",   o_disparity, 0);
    chk("seed_after_gap_filled", o_filled,    1);

    // Reset mid-row
    do_reset();
    px(1'b1, 8'd10, 1'b0);
    px(1'b1, 8'd11, 1'b0);
    px(1'b1, 8'd12, 1'b0);
    @(negedge clk);
    vin = 1'b1; din = 8'd13; hin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_disp",  o_disparity, 0);
    chk("mid_rst_valid", o_valid,     0);
    chk("mid_rst_eol",   o_eol,       0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_disp",   o_disparity, 0);
    chk("mid_rst_hold_filled", o_filled,    0);
    @(negedge clk);
    vin = 1'b0;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      px(1'b1, 8'($urandom_range(1, 255)), 1'b0);
      chk("mid_rst_eol_pos", o_eol, (i == 7));
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      px($urandom_range(0, 9) < 7, rd, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
